// File: rtl/stream_pkg.sv
// Shared definitions for the result streamer and the down-sample CPU top.
// Holds the FSM state enum, the RAM/stream widths and the default RAM read
// latency.
package stream_pkg;

    localparam int STREAM_ADDR_W = 16;
    localparam int STREAM_DATA_W = 8;
    localparam int STREAM_RD_LAT = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        SEND    = 3'd4,
        CKSUM   = 3'd5,
        DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/rise_detect.sv
// Registered copy of a level input plus a rising-edge pulse.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset (clears the registered copy)
//   din   - level input
//   rise  - high for the cycle where din is 1 and its registered copy is 0
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) din_q <= 1'b0;
        else       din_q <= din;
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/ram_result_streamer.sv
// Result streamer: on a rising edge of `finished` it takes over the data RAM
// read port and sends dump_len bytes starting at start_addr on a valid/ready
// byte stream.
// Ports:
//   clk, reset            - system clock, asynchronous active-high reset
//   finished              - CPU program-complete level (rising edge triggers)
//   start_addr, dump_len  - window, sampled on trigger (dump_len=0 is empty)
//   bus_own               - block owns the RAM port (top forces wea=0)
//   mem_addr, mem_rdata   - RAM read address / read data
//   tx_data, tx_valid, tx_ready - byte stream
//   busy, done            - streaming in progress / window sent
// Build option: RESULT_STREAM_CHECKSUM_EN appends a mod-256 sum byte.
//
// state   | meaning
// IDLE    | waiting for a finished rise
// SETUP   | drive mem_addr with the current byte address
// WAIT    | RAM read latency (RD_LAT-1 cycles)
// CAPTURE | register mem_rdata into tx_data
// SEND    | present byte until accepted
// CKSUM   | present checksum byte until accepted (option only)
// DONE    | window sent; wait for finished to fall
module ram_result_streamer
    import stream_pkg::*;
#(
    parameter int ADDR_W = STREAM_ADDR_W,
    parameter int DATA_W = STREAM_DATA_W,
    parameter int RD_LAT = STREAM_RD_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              finished,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] dump_len,
    output logic              bus_own,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    // WAIT lasts RD_LAT-1 cycles; SETUP's mem_addr register supplies the rest.
    localparam logic [3:0] WAIT_LOAD = 4'(RD_LAT - 2);

`ifdef RESULT_STREAM_CHECKSUM_EN
    localparam state_t END_ST = CKSUM;
`else
    localparam state_t END_ST = DONE;
`endif

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] remaining;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        wait_cnt;
    logic              trig;
    logic              hs;
    logic              last;

    rise_detect u_rise (
        .clk   (clk),
        .reset (reset),
        .din   (finished),
        .rise  (trig)
    );

    assign hs   = tx_valid & tx_ready;
    assign last = (remaining == ADDR_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (trig) state_nx = (dump_len == '0) ? END_ST : SETUP;
            SETUP:   state_nx = WAIT;
            WAIT:    if (wait_cnt == 4'd0) state_nx = CAPTURE;
            CAPTURE: state_nx = SEND;
            SEND:    if (hs) state_nx = last ? END_ST : SETUP;
            CKSUM:   if (hs) state_nx = DONE;
            DONE:    if (!finished) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decode straight from state so reset drops them asynchronously.
    always_comb begin
        bus_own  = 1'b0;
        busy     = 1'b0;
        tx_valid = 1'b0;
        done     = 1'b0;
        case (state)
            SETUP, WAIT, CAPTURE: begin
                bus_own = 1'b1;
                busy    = 1'b1;
            end
            SEND: begin
                bus_own  = 1'b1;
                busy     = 1'b1;
                tx_valid = 1'b1;
            end
            CKSUM: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

`ifdef RESULT_STREAM_CHECKSUM_EN
    logic [DATA_W-1:0] cksum;
    assign tx_data = (state == CKSUM) ? cksum : data_q;
`else
    assign tx_data = data_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr      <= '0;
            remaining <= '0;
            mem_addr  <= '0;
            data_q    <= '0;
            wait_cnt  <= '0;
`ifdef RESULT_STREAM_CHECKSUM_EN
            cksum     <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (trig) begin
                    addr      <= start_addr;
                    remaining <= dump_len;
`ifdef RESULT_STREAM_CHECKSUM_EN
                    cksum     <= '0;
`endif
                end
                SETUP: begin
                    mem_addr <= addr;
                    wait_cnt <= WAIT_LOAD;
                end
                WAIT:    if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                CAPTURE: data_q <= mem_rdata;
                SEND: if (hs) begin
                    addr      <= addr + ADDR_W'(1);
                    remaining <= remaining - ADDR_W'(1);
`ifdef RESULT_STREAM_CHECKSUM_EN
                    cksum     <= cksum + data_q;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_result_streamer.sv
module tb_ram_result_streamer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        finished = 1'b0;
    logic [15:0] start_addr = '0;
    logic [15:0] dump_len = '0;
    logic        bus_own;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic        done;

    ram_result_streamer dut (
        .clk        (clk),
        .reset      (reset),
        .finished   (finished),
        .start_addr (start_addr),
        .dump_len   (dump_len),
        .bus_own    (bus_own),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Data RAM: registered read port.
    logic [7:0] ram [0:65535];
    always @(posedge clk) mem_rdata <= ram[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference stream for the current window.
    logic [7:0]  exp_data[$];
    logic [15:0] exp_addr[$];
    bit          exp_isdata[$];
    int          n_exp, n_seen, prev_hs, last_hs;
    bit          ready_rand = 0;
    int          stall_idx = -1;
    int          stall_left = 0;
    bit          bus_own_seen = 0;

    task automatic plan(input logic [15:0] st, input int len);
        logic [7:0]  sum;
        logic [15:0] a;
        exp_data.delete(); exp_addr.delete(); exp_isdata.delete();
        sum = 8'h00;
        for (int i = 0; i < len; i++) begin
            a = st + 16'(i);
            exp_data.push_back(ram[a]);
            exp_addr.push_back(a);
            exp_isdata.push_back(1'b1);
            sum = sum + ram[a];
        end
`ifdef RESULT_STREAM_CHECKSUM_EN
        exp_data.push_back(sum);
        exp_addr.push_back(16'h0);
        exp_isdata.push_back(1'b0);
`endif
        n_exp   = exp_data.size();
        n_seen  = 0;
        prev_hs = -1;
        last_hs = -1;
    endtask

    // Sink + stream monitor: tx_ready is changed on the falling edge and the
    // handshake the DUT will see at the next rising edge is evaluated here.
    always @(negedge clk) begin
        if (reset) begin
            tx_ready = 1'b0;
        end else begin
            if (bus_own) bus_own_seen = 1'b1;
            if (tx_valid && n_seen == stall_idx && stall_left > 0) begin
                tx_ready = 1'b0;
                stall_left--;
                if (exp_data.size() > 0) begin
                    chk("stall_data", 32'(tx_data), 32'(exp_data[0]));
                    if (exp_isdata[0]) chk("stall_addr", 32'(mem_addr), 32'(exp_addr[0]));
                end
            end else begin
                tx_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (tx_valid && tx_ready) begin
                if (exp_data.size() == 0) begin
                    chk("stream_len", 32'(n_seen + 1), 32'(n_exp));
                end else begin
                    chk("data", 32'(tx_data), 32'(exp_data[0]));
                    if (exp_isdata[0]) begin
                        chk("addr", 32'(mem_addr), 32'(exp_addr[0]));
                        chk("bus_own", 32'(bus_own), 32'd1);
                        if (!ready_rand && stall_idx < 0 && prev_hs >= 0)
                            chk("gap", 32'(cyc - prev_hs), 32'd4);
                        prev_hs = cyc;
                    end
                    void'(exp_data.pop_front());
                    void'(exp_addr.pop_front());
                    void'(exp_isdata.pop_front());
                end
                n_seen++;
                last_hs = cyc;
            end
        end
    end

    task automatic run(input logic [15:0] st, input int len, input bit rnd,
                       input int sidx, input int slen, input bit retrig);
        int t0;
        bit got;
        plan(st, len);
        ready_rand   = rnd;
        stall_idx    = sidx;
        stall_left   = slen;
        bus_own_seen = 1'b0;
        start_addr   = st;
        dump_len     = 16'(len);
        @(negedge clk);
        finished = 1'b1;
        t0  = cyc;
        got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge clk);
            if (retrig && k == 3) finished = 1'b0;
            if (retrig && k == 5) finished = 1'b1;
            if (done) got = 1'b1;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("stream_len", 32'(n_seen), 32'(n_exp));
        if (n_seen > 0) chk("done_lat", 32'(cyc - last_hs), 32'd1);
`ifndef RESULT_STREAM_CHECKSUM_EN
        if (len == 0) begin
            chk("len0_lat_le2", 32'((cyc - t0) <= 2), 32'd1);
            chk("len0_bus_own", 32'(bus_own_seen), 32'd0);
        end
`endif
        chk("done_bus_own", 32'(bus_own), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        finished = 1'b0;
        @(negedge clk);
        chk("done_clear", 32'(done), 32'd0);
        stall_idx  = -1;
        stall_left = 0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        ram[16'h0100] = 8'h11; ram[16'h0101] = 8'h22;
        ram[16'h0102] = 8'h33; ram[16'h0103] = 8'h44;
        ram[16'hFFFE] = 8'h01; ram[16'hFFFF] = 8'h02; ram[16'h0000] = 8'h03;

        repeat (3) @(negedge clk);
        chk("rst_bus_own", 32'(bus_own), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Basic window, back-to-back ready
        run(16'h0100, 4, 0, -1, 0, 0);
        // Ten-cycle stall on the second byte
        run(16'h0100, 4, 0, 1, 10, 0);
        // Address wrap
        run(16'hFFFE, 3, 0, -1, 0, 0);
        // Empty window
        run(16'h1234, 0, 0, -1, 0, 0);
        // Retrigger while busy, then a fresh rise restarts
        run(16'h0100, 4, 0, -1, 0, 1);
        run(16'h0100, 4, 0, -1, 0, 0);

        // Reset while a byte is being presented
        plan(16'h0100, 4);
        ready_rand = 0; stall_idx = 0; stall_left = 1000;
        start_addr = 16'h0100; dump_len = 16'd4;
        @(negedge clk);
        finished = 1'b1;
        for (int k = 0; k < 50 && !tx_valid; k++) @(negedge clk);
        chk("pre_rst_valid", 32'(tx_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_tx_valid", 32'(tx_valid), 32'd0);
        chk("arst_bus_own", 32'(bus_own), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_mem_addr", 32'(mem_addr), 32'd0);
        stall_idx = -1; stall_left = 0;
        exp_data.delete(); exp_addr.delete(); exp_isdata.delete();
        finished = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run(16'h0100, 4, 0, -1, 0, 0);

        // Randomized windows and sink behaviour
        for (int r = 0; r < 10; r++) begin
            logic [15:0] st;
            int len;
            st  = (r % 3 == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
            len = $urandom_range(0, 12);
            run(st, len, 1'($urandom_range(0, 1)), -1, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_result_streamer.md
Name: ram_result_streamer

Overview:
- Downstream consumer of the down-sample CPU's data RAM.
- When the CPU raises `finished`, the block takes over the RAM port and reads a result window of `dump_len` bytes starting at `start_addr`.
- Each byte is emitted on a valid/ready byte stream toward a UART TX or host link.
- The top level muxes RAM address and write-enable to this block whenever `bus_own`=1.

Parameters:
- ADDR_W, 16, RAM address width (matches 16-bit data RAM address).
- DATA_W, 8, RAM/stream data width.
- RD_LAT, 2, cycles from `mem_addr` update to valid `mem_rdata` (synchronous RAM clocked on clk).

Ports:
- clk  in  1  system clock, same clk as data RAM.
- reset  in  1  asynchronous, active-high reset.
- finished  in  1  CPU program-complete level.
- start_addr  in  ADDR_W  first RAM byte to stream; sampled on trigger.
- dump_len  in  ADDR_W  byte count; sampled on trigger; 0 = empty window.
- bus_own  out  1  block owns RAM port; top forces RAM wea=0 and addra=`mem_addr`.
- mem_addr  out  ADDR_W  RAM read address.
- mem_rdata  in  DATA_W  RAM douta.
- tx_data  out  DATA_W  stream byte.
- tx_valid  out  1  stream byte valid.
- tx_ready  in  1  sink accepts byte.
- busy  out  1  streaming in progress.
- done  out  1  window fully sent; held until `finished` falls.

Behaviour:
- Reset (async) forces state IDLE.
  - All outputs 0: bus_own, mem_addr, tx_data, tx_valid, busy, done.
  - Internal count and finished_q cleared.
  - Reset mid-stream drops tx_valid immediately. The partial stream is abandoned, not resumed.
- Trigger: rising edge of `finished` (finished & ~finished_q, registered). Only honoured in IDLE; ignored in every other state.
- States:
  - IDLE: on trigger, latch addr=start_addr and remaining=dump_len; set bus_own=1 and busy=1; go to SETUP. If dump_len=0, go straight to DONE instead.
  - SETUP: mem_addr=addr is driven (registered).
  - WAIT: one cycle.
  - CAPTURE: tx_data<=mem_rdata, tx_valid<=1. Captured exactly RD_LAT edges after mem_addr changed.
  - SEND: hold tx_data/tx_valid stable while tx_ready=0.
    - On tx_valid&tx_ready: tx_valid<=0, addr<=addr+1, remaining<=remaining-1.
    - If remaining was 1, go to DONE; else go to SETUP.
  - DONE: bus_own=0, busy=0, done=1. When finished=0, done<=0 and go to IDLE.
- Throughput: with tx_ready tied high, one byte per 4 cycles (SETUP, WAIT, CAPTURE, SEND).
- Address arithmetic is ADDR_W-bit modulo: 0xFFFF+1 wraps to 0x0000, and the window continues.
- mem_addr is held constant from SETUP through SEND for each byte.
- bus_own is high from the cycle after the trigger until DONE entry. The block never drives a write.
- tx_ready asserted without tx_valid is ignored.

Optional Feature:
- Macro: RESULT_STREAM_CHECKSUM_EN.
- Defined:
  - An 8-bit modulo-256 sum of all streamed bytes is accumulated (cleared on trigger).
  - After the last data byte handshake, state CKSUM presents the sum with tx_valid=1 until accepted, then goes to DONE.
  - dump_len=0 sends a single 0x00 checksum byte.
- Undefined: no CKSUM state; the stream ends on the last data byte.

Decomposition:
- Shared package `stream_pkg`:
  - State enum: IDLE, SETUP, WAIT, CAPTURE, SEND, CKSUM, DONE.
  - RD_LAT default.
  - Width constants ADDR_W/DATA_W shared with the CPU top.
- One natural sub-module, `rise_detect`: registered finished plus rising-edge pulse. It is reused by the top for the start of run.

Test Plan:
- Preload RAM[0x0100..0x0103]=0x11,0x22,0x33,0x44; start_addr=0x0100, dump_len=4; pulse finished high; tx_ready=1.
  -> Stream 0x11,0x22,0x33,0x44.
  -> Each byte 4 cycles apart; bus_own high throughout; done=1 after the 4th byte.
  -> With macro: a 5th byte 0xAA follows.
- Same window, tx_ready low for 10 cycles on byte 2.
  -> tx_data=0x22 and tx_valid remain stable for all 10 cycles; no address advance; byte 3 follows correctly.
- start_addr=0xFFFE, dump_len=3, RAM[0xFFFE]=0x01, [0xFFFF]=0x02, [0x0000]=0x03.
  -> Stream 0x01,0x02,0x03; mem_addr wraps to 0x0000.
- dump_len=0 with finished rise.
  -> No tx_valid (without macro); done=1 within 2 cycles; bus_own never asserted.
  -> With macro: a single 0x00 byte.
- finished toggled low/high while busy on byte 1 of 4.
  -> Retrigger ignored; all 4 bytes sent once.
  -> After done, finished=0 clears done; a new rise restarts the stream.
- Assert reset in SEND with tx_valid=1.
  -> tx_valid, bus_own, busy drop asynchronously; state IDLE; a later finished rise streams from the start.
